// File: rtl/sdp_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdp_ram_pkg                                               |
// | Brief    : Shared types and helpers for the byte-enabled SDP RAM.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package sdp_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram_be_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdp_ram_be_if                                             |
// | Brief    : Write/read request and response bundle of the SDP RAM.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface sdp_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdp_ram_rd_pipe                                           |
// | Brief    : LATENCY-deep {valid,data} delay line, flushed by rst.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_valid,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data
);
    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_d [LATENCY];

    // Data stages only load on a valid beat so the output holds its last result.
    always_comb begin
        valid_d[0] = i_valid;
        data_d[0]  = i_valid ? i_data : data_q[0];
        for (int s = 1; s < LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) data_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < LATENCY; s++) data_q[s] <= data_d[s];
        end
    end

    assign o_valid = valid_q[LATENCY-1];
    assign o_data  = data_q[LATENCY-1];
endmodule
`default_nettype wire

// File: rtl/sdp_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdp_ram_be                                                |
// | Brief    : Simple dual-port RAM, byte enables, hardware zero-init.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sdp_ram_be
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    sdp_ram_be_if.slave bus
);
    localparam int                  c_num_bytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
        $error("sdp_ram_be: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_chk_depth
        $error("sdp_ram_be: DEPTH must lie in 1..2**ADDR_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
        $error("sdp_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
        $error("sdp_ram_be: RDW_MODE must be 0 or 1");
    end

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_busy_q, init_busy_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [c_num_bytes-1:0] mem_wbe;
    logic                   wr_in_range, rd_in_range, rd_accept, rdw_hit;
    logic [DATA_WIDTH-1:0]  rd_old, rd_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == c_last_addr) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
        init_busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign wr_in_range = {1'b0, bus.wr_addr} < c_depth_ext;
    assign rd_in_range = {1'b0, bus.rd_addr} < c_depth_ext;

    // The zero-fill sequence borrows the write port while INIT owns the array.
    always_comb begin
        if (state_q == INIT) begin
            mem_we    = !rst;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else begin
            mem_we    = !rst && bus.wr_en && wr_in_range;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
            mem_wbe   = bus.wr_be;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < c_num_bytes; i++) begin
                if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign rd_accept = !rst && (state_q == RUN) && bus.rd_en;
    assign rd_old    = rd_in_range ? mem[bus.rd_addr] : '0;
    assign rdw_hit   = (RDW_MODE == RDW_NEW) && (state_q == RUN) && bus.wr_en
                       && wr_in_range && (bus.wr_addr == bus.rd_addr);

    for (genvar b = 0; b < c_num_bytes; b++) begin : g_rdw_merge
        assign rd_word[8*b +: 8] = rdw_hit
            ? byte_merge(rd_old[8*b +: 8], bus.wr_data[8*b +: 8], bus.wr_be[b])
            : rd_old[8*b +: 8];
    end

    sdp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (rd_accept),
        .i_data  (rd_word),
        .o_valid (bus.rd_valid),
        .o_data  (bus.rd_data)
    );

    assign bus.init_busy = init_busy_q;
endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sdp_ram_be                                             |
// | Brief    : Three RAM configurations driven in lockstep vs. a model.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sdp_ram_be;
    localparam int NDUT = 3;
    // Instance k: depth / read latency / read-during-write mode.
    localparam int DEP [NDUT] = '{64, 64, 48};
    localparam int LAT [NDUT] = '{1, 2, 2};
    localparam int RDW [NDUT] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    always #5 clk = ~clk;

    sdp_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if0 ();
    sdp_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if1 ();
    sdp_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) if2 ();

    assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;  assign if2.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data; assign if2.wr_data = wr_data;
    assign if0.wr_be = wr_be;  assign if1.wr_be = wr_be;  assign if2.wr_be = wr_be;
    assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;  assign if2.rd_en = rd_en;
    assign if0.rd_addr = rd_addr; assign if1.rd_addr = rd_addr; assign if2.rd_addr = rd_addr;

    sdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64), .READ_LATENCY(1), .RDW_MODE(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    sdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64), .READ_LATENCY(2), .RDW_MODE(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    sdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .READ_LATENCY(2), .RDW_MODE(0))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        dv [NDUT];
    logic        dbusy [NDUT];
    logic [31:0] dd [NDUT];
    assign dv[0] = if0.rd_valid;     assign dv[1] = if1.rd_valid;     assign dv[2] = if2.rd_valid;
    assign dbusy[0] = if0.init_busy; assign dbusy[1] = if1.init_busy; assign dbusy[2] = if2.init_busy;
    assign dd[0] = if0.rd_data;      assign dd[1] = if1.rd_data;      assign dd[2] = if2.rd_data;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: memory contents, remaining init cycles, and results
    // scheduled into a slot ring indexed by the cycle they become visible.
    int          rem [NDUT];
    logic [31:0] mm [NDUT][64];
    logic        sv [NDUT][4];
    logic [31:0] sd [NDUT][4];
    logic        cur_v [NDUT];
    logic [31:0] cur_d [NDUT];
    logic        cur_rst [NDUT];
    logic        exp_busy [NDUT];
    int          cyc = 0;
    logic        model_ok = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < NDUT; k++) begin
                if (rst) begin
                    rem[k] = DEP[k];
                    for (int a = 0; a < 64; a++) mm[k][a] = 32'h0;
                    for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
                    cur_rst[k] = 1'b1;
                end else begin
                    cur_rst[k] = 1'b0;
                    if (rem[k] > 0) begin
                        rem[k]--;
                    end else begin
                        if (rd_en) begin
                            logic [31:0] r;
                            if (int'(rd_addr) >= DEP[k]) begin
                                r = 32'h0;
                            end else begin
                                r = mm[k][rd_addr];
                                if (RDW[k] == 1 && wr_en && wr_addr == rd_addr)
                                    for (int b = 0; b < 4; b++)
                                        if (wr_be[b]) r[8*b +: 8] = wr_data[8*b +: 8];
                            end
                            sv[k][(cyc + LAT[k] - 1) % 4] = 1'b1;
                            sd[k][(cyc + LAT[k] - 1) % 4] = r;
                        end
                        if (wr_en && int'(wr_addr) < DEP[k])
                            for (int b = 0; b < 4; b++)
                                if (wr_be[b]) mm[k][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                cur_v[k] = sv[k][cyc % 4];
                cur_d[k] = cur_rst[k] ? 32'h0 : sd[k][cyc % 4];
                sv[k][cyc % 4] = 1'b0;
                exp_busy[k] = (rem[k] > 0);
            end
            model_ok = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                for (int k = 0; k < NDUT; k++) begin
                    check($sformatf("d%0d_init_busy@%0d", k, cyc), 32'(dbusy[k]), 32'(exp_busy[k]));
                    check($sformatf("d%0d_rd_valid@%0d", k, cyc), 32'(dv[k]), 32'(cur_v[k]));
                    if (cur_v[k] || cur_rst[k])
                        check($sformatf("d%0d_rd_data@%0d", k, cyc), dd[k], cur_d[k]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic expect_out(input string name, input int k, input logic v, input logic [31:0] d);
        check({name, "_valid"}, 32'(dv[k]), 32'(v));
        if (v) check({name, "_data"}, dd[k], d);
    endtask

    task automatic wait_init_done(input string name);
        int n = 0;
        while ((dbusy[0] || dbusy[1] || dbusy[2]) && n < 200) begin
            n++;
            tick();
        end
        check(name, 32'(dbusy[0] | dbusy[1] | dbusy[2]), 32'h0);
    endtask

    initial begin
        int nA, nC, n;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Count busy cycles while hammering address 3 during INIT.
        nA = 0; nC = 0; n = 0;
        while ((dbusy[0] || dbusy[1] || dbusy[2]) && n < 200) begin
            if (n >= 1 && n <= 5) expect_out("init_ignored_rd", 0, 1'b0, 32'h0);
            wr_en = (n < 5); wr_addr = 6'd3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
            rd_en = (n < 5); rd_addr = 6'd3;
            if (dbusy[0]) nA++;
            if (dbusy[2]) nC++;
            n++;
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("init_busy_cycles_d64", 32'(nA), 32'd64);
        check("init_busy_cycles_d48", 32'(nC), 32'd48);

        for (int a = 0; a < 64; a++) begin
            rd_en = 1'b1; rd_addr = 6'(a);
            tick();
            if (a == 3) expect_out("init_zero_addr3", 0, 1'b1, 32'h0);
        end
        rd_en = 1'b0;
        repeat (3) tick();

        wr(6'd5, 32'hAABBCCDD, 4'hF);
        wr(6'd5, 32'h11223344, 4'b0101);
        rd(6'd5);
        expect_out("be_merge_l1", 0, 1'b1, 32'hAA22CC44);
        check("be_merge_l2_early", 32'(dv[1]), 32'h0);
        tick();
        expect_out("be_merge_l2", 1, 1'b1, 32'hAA22CC44);
        check("be_merge_l1_single", 32'(dv[0]), 32'h0);
        tick();

        wr(6'd9, 32'h12345678, 4'hF);
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 6'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        expect_out("rdw_old", 0, 1'b1, 32'h12345678);
        tick();
        expect_out("rdw_new", 1, 1'b1, 32'h1234FFFF);
        expect_out("rdw_old_l2", 2, 1'b1, 32'h12345678);
        tick();

        for (int i = 0; i < 8; i++) wr(6'(i), 32'hC0DE0000 | 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = 6'(i);
            tick();
            if (i >= 1) expect_out($sformatf("b2b_%0d", i - 1), 1, 1'b1, 32'hC0DE0000 | 32'(i - 1));
        end
        rd_en = 1'b0;
        tick();
        expect_out("b2b_7", 1, 1'b1, 32'hC0DE0007);
        tick();
        check("b2b_drain", 32'(dv[1]), 32'h0);

        wr(6'd50, 32'h5A5A5A5A, 4'hF);
        rd(6'd50);
        expect_out("oob_inrange_d64", 0, 1'b1, 32'h5A5A5A5A);
        tick();
        expect_out("oob_d48", 2, 1'b1, 32'h0);
        tick();

        // Reset lands with a latency-2 read still in flight.
        rd_en = 1'b1; rd_addr = 6'd5;
        tick();
        rd_addr = 6'd6;
        tick();
        rst = 1'b1; rd_en = 1'b0;
        tick();
        check("rst_flush_d0", 32'(dv[0]), 32'h0);
        check("rst_flush_d1", 32'(dv[1]), 32'h0);
        check("rst_flush_d2", 32'(dv[2]), 32'h0);
        tick();
        rst = 1'b0;
        wait_init_done("reinit_done");
        rd(6'd5);
        expect_out("rezero_addr5_l1", 0, 1'b1, 32'h0);
        tick();
        expect_out("rezero_addr5_l2", 1, 1'b1, 32'h0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
